pending_priority_encoder: RTL and testbench
===========================================

Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the team's fixed 9-input priority encoder.
- Captures rising edges on N request lines into a pending register and applies a per-line mask.
- Presents the highest-priority pending line as an encoded ID (index+1, 0 = none) through a valid/ack handshake.
- Sits between peripheral event lines and the controller FSM as the event/interrupt front end.

Parameters:
- N, 9, number of request lines (2..64).
- IDW, $clog2(N+1), width of encoded ID; ID 0 reserved for "none".

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines; a 0->1 transition is one event.
- mask  input  N  1 = line enabled for grant. Pending still latches while masked.
- valid  output  1  grant presented on id.
- id  output  IDW  granted line index+1; 0 whenever valid=0.
- ack  input  1  consumer accepts grant; meaningful only when valid=1.
- pending  output  N  current pending register, for status readback.
- overrun  output  1  one-cycle pulse: a new event arrived on a line already pending.

Behaviour:
- Reset (async assert; release synchronous to clk): req_q=0, pending=0, valid=0, id=0, overrun=0, state=IDLE. Reset mid-handshake drops the grant and all pending events.
- Edge detect: rise = req & ~req_q; req_q <= req every cycle. A req held high generates one event only.
- Pending update each cycle: pending <= (pending & ~clr) | rise. clr is the one-hot of the granted line when valid & ack, else 0.
- Set wins over clear: if a new rise lands on the line being acked in the same cycle, the bit stays 1.
- overrun <= |(rise & pending & ~clr). It is registered and asserted for exactly one cycle.
- Candidate vector: cand = pending & mask. In fixed mode the highest set index wins (index N-1 is highest priority, matching the existing encoder).
- FSM, two states:
  - IDLE: if |cand, register id <= winner+1 and valid <= 1, then go to PRESENT. Otherwise stay with valid=0, id=0.
  - PRESENT: id and valid held stable regardless of req/mask changes. A grant is never retracted or re-prioritised. On ack: valid <= 0, id <= 0, pending bit cleared, return to IDLE.
- Latency:
  - First rising clk edge sampling req=1 sets pending.
  - valid rises at the next edge (2 cycles from req to valid).
  - After ack, at least one IDLE cycle with valid=0 before the next grant. Maximum throughput is one grant per 2 cycles plus the ack wait.
- ack while valid=0 is ignored.
- Masking a presented line does not cancel it. Unmasking a pending line makes it eligible in the next IDLE evaluation.
- All N bits equal 0 in cand: no grant, no state change.

Optional Feature:
- Macro: PPE_ROUND_ROBIN_EN.
- Defined:
  - Adds register last (IDW bits, reset 0).
  - On each ack, last <= granted index.
  - Priority rotates: the search starts at index last-1 and goes downward, wrapping from 0 to N-1. The just-served line becomes lowest priority.
  - With last=0 after reset, behaviour equals fixed mode.
- Not defined: strict fixed priority; the register and rotate logic are absent.

Decomposition:
- Package ppe_pkg:
  - state enum {IDLE, PRESENT}.
  - ID_NONE = 0.
  - Function id_width(n) returning $clog2(n+1).
- Sub-module prio_enc_n:
  - Combinational, parameter N.
  - Inputs: vector and start index.
  - Outputs: found flag and winner index.
  - Rotate-then-encode, with start fixed at N-1 when round robin is off.
- Top holds the edge detect, pending register, FSM and output registers.

Test Plan (N=9, IDW=4):
- Reset/idle: rst pulse, req=0 -> valid=0, id=0, pending=0; ack pulses ignored.
- Priority: mask=all 1s, req[2], req[7] and req[0] rise in the same cycle -> pending=0x085. Grants arrive in order id=8, 3, 1, each after ack with one idle cycle between.
- Level vs edge: req[4] held high for 20 cycles -> exactly one grant id=5. overrun stays 0.
- Overrun and set-wins:
  - req[1] toggles 1-0-1 while pending -> overrun pulses one cycle.
  - A req[1] rise in the ack cycle of id=2 -> pending[1] stays 1 and a second grant id=2 follows.
- Mask/stability:
  - mask[8]=0 with pending[8]=1 and pending[3]=1 -> grant id=4.
  - Clearing mask[3] during PRESENT keeps id=4 until ack.
  - Then setting mask[8]=1 -> next grant id=9.
- Round robin (PPE_ROUND_ROBIN_EN): lines 8 and 6 pending, ack 9, then line 8 re-raised -> next grant id=7, not 9. Async reset mid-PRESENT -> valid=0 immediately and last=0.

Source files
------------

// File: rtl/pending_priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppe_pkg
// Description : Shared types and helpers for the pending priority encoder.
//               It provides the FSM state encoding, the reserved "no grant"
//               ID and the ID width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ppe_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Encoded ID 0 means "no line granted"; real lines are index+1.
  localparam int ID_NONE = 0;

  function automatic int id_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pending_priority_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : pending_priority_encoder_if
// Description : Event / grant bundle between the request producers, the
//               encoder and the consuming controller.
//   req     : N request lines, a rising edge is one event
//   mask    : N per-line grant enables
//   ack     : consumer accepts the presented grant
//   valid   : a grant is presented on id
//   id      : granted line index+1, 0 when nothing is granted
//   pending : pending register readback
//   overrun : one-cycle pulse, new event on an already pending line
//   Modport master drives req/mask/ack; modport slave is the encoder side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pending_priority_encoder_if
  import ppe_pkg::*;
#(
  parameter int N   = 9,
  parameter int IDW = id_width(N)
);

  logic [N-1:0]   req;
  logic [N-1:0]   mask;
  logic           ack;
  logic           valid;
  logic [IDW-1:0] id;
  logic [N-1:0]   pending;
  logic           overrun;

  modport master (
    output req, mask, ack,
    input  valid, id, pending, overrun
  );

  modport slave (
    input  req, mask, ack,
    output valid, id, pending, overrun
  );

endinterface
`default_nettype wire

// File: rtl/pending_priority_encoder_prio_enc_n.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_n
// Description : Combinational rotating priority encoder. The search starts
//               at i_start and walks downward, wrapping from 0 to N-1; the
//               first set bit found wins. With i_start = N-1 this is a plain
//               "highest index wins" encoder.
//   i_vec    : candidate vector
//   i_start  : index with highest priority
//   o_found  : any bit of i_vec set
//   o_winner : index of the winning bit (0 when o_found = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_n #(
  parameter int N  = 9,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]  i_vec,
  input  wire logic [IW-1:0] i_start,
  output logic               o_found,
  output logic [IW-1:0]      o_winner
);

  int w_idx;

  // Rotate-then-encode expressed as a walk: distance k from i_start maps to
  // physical index (i_start - k) mod N. Walking from the farthest distance
  // toward k = 0 lets the closest set bit overwrite the others, so the
  // highest-priority line is the last assignment.
  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(i_start) - k;
      if (w_idx < 0) begin
        w_idx = w_idx + N;
      end
      if (i_vec[w_idx[IW-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_idx[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : pending_priority_encoder
// Description : Registered event front end. Rising edges on the request
//               lines are latched into a pending register; the highest
//               priority pending and enabled line is presented as an encoded
//               ID through a valid/ack handshake.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : pending_priority_encoder_if.slave (req, mask, ack in;
//             valid, id, pending, overrun out)
//   Build option PPE_ROUND_ROBIN_EN: rotate priority so the line served last
//   becomes lowest priority. Undefined: strict fixed priority, N-1 highest.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_priority_encoder
  import ppe_pkg::*;
#(
  parameter int N   = 9,
  parameter int IDW = id_width(N)
) (
  input wire logic                 clk,
  input wire logic                 rst,
  pending_priority_encoder_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   r_req_q;
  logic [N-1:0]   r_pending;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic           r_overrun;
  state_t         r_state;

  state_t         w_state_d;
  logic           w_valid_d;
  logic [IDW-1:0] w_id_d;

  logic [N-1:0]   w_rise;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_cand;
  logic           w_ack_eff;
  logic [IDW-1:0] w_gidx;
  logic [IW-1:0]  w_start;
  logic           w_found;
  logic [IW-1:0]  w_winner;

  assign w_rise    = bus.req & ~r_req_q;
  // ack only counts while a grant is actually presented.
  assign w_ack_eff = (r_state == PRESENT) & bus.ack;
  assign w_gidx    = r_id - IDW'(1);
  assign w_clr     = w_ack_eff ? (N'(1) << w_gidx) : '0;
  assign w_cand    = r_pending & bus.mask;

`ifdef PPE_ROUND_ROBIN_EN
  logic [IDW-1:0] r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_ack_eff) begin
      r_last <= w_gidx;
    end
  end

  // Start just below the last served line; last = 0 wraps to N-1, which is
  // also the fixed-priority start point used right after reset.
  assign w_start = (r_last == '0) ? IW'(N - 1) : IW'(r_last - IDW'(1));
`else
  assign w_start = IW'(N - 1);
`endif

  prio_enc_n #(
    .N  (N),
    .IW (IW)
  ) u_prio_enc (
    .i_vec    (w_cand),
    .i_start  (w_start),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Next-state and next-output logic. A presented grant is frozen until ack
  // regardless of later req/mask activity.
  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_id_d    = r_id;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_d = PRESENT;
          w_valid_d = 1'b1;
          w_id_d    = IDW'(w_winner) + IDW'(1);
        end else begin
          w_valid_d = 1'b0;
          w_id_d    = IDW'(ID_NONE);
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          w_state_d = IDLE;
          w_valid_d = 1'b0;
          w_id_d    = IDW'(ID_NONE);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_valid_d = 1'b0;
        w_id_d    = IDW'(ID_NONE);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= IDW'(ID_NONE);
    end else begin
      r_state <= w_state_d;
      r_valid <= w_valid_d;
      r_id    <= w_id_d;
    end
  end

  // A rise on the line being acked in the same cycle is a fresh event, so
  // set dominates clear and no overrun is flagged for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_req_q   <= bus.req;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overrun <= |(w_rise & r_pending & ~w_clr);
    end
  end

  assign bus.valid   = r_valid;
  assign bus.id      = r_id;
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pending_priority_encoder
// Description : Self-checking bench for pending_priority_encoder (N=9).
//               Directed stimulus with literal expectations, plus a cycle
//               model of the event/grant rules compared on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pending_priority_encoder;

  localparam int N   = 9;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  pending_priority_encoder_if #(.N(N), .IDW(IDW)) bus ();

  pending_priority_encoder #(.N(N), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_pend [N];
  bit m_prev [N];
  bit m_valid;
  int m_id;
  bit m_over;
  int m_last;
  int m_served, m_start, m_pick;
  bit m_rise;
  bit m_next [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_id    = 0;
      m_over  = 1'b0;
      m_last  = 0;
    end else begin
      m_served = (m_valid && bus.ack) ? m_id - 1 : -1;
      m_over   = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_rise = bus.req[i] && !m_prev[i];
        if (m_rise && m_pend[i] && i != m_served) m_over = 1'b1;
        m_next[i] = (m_pend[i] && i != m_served) || m_rise;
      end
      if (!m_valid) begin
`ifdef PPE_ROUND_ROBIN_EN
        m_start = (m_last == 0) ? N - 1 : m_last - 1;
`else
        m_start = N - 1;
`endif
        m_pick = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_start - k + N) % N;
          if (m_pick < 0 && m_pend[j] && bus.mask[j]) m_pick = j;
        end
        if (m_pick >= 0) begin
          m_valid = 1'b1;
          m_id    = m_pick + 1;
        end
      end else if (bus.ack) begin
        m_last  = m_id - 1;
        m_valid = 1'b0;
        m_id    = 0;
      end
      for (int i = 0; i < N; i++) begin
        m_pend[i] = m_next[i];
        m_prev[i] = bus.req[i];
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] exp_pend;
      for (int i = 0; i < N; i++) exp_pend[i] = m_pend[i];
      check("model_valid",   64'(bus.valid),   64'(m_valid));
      check("model_id",      64'(bus.id),      64'(m_id));
      check("model_pending", 64'(bus.pending), 64'(exp_pend));
      check("model_overrun", 64'(bus.overrun), 64'(m_over));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input int exp_id);
    check({name, "_valid"}, 64'(bus.valid), 64'd1);
    check({name, "_id"},    64'(bus.id),    64'(exp_id));
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("ack_drops_valid", 64'(bus.valid), 64'd0);
    check("ack_drops_id",    64'(bus.id),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req  = '0;
    bus.mask = '1;
    bus.ack  = 1'b0;

    // Reset / idle
    repeat (2) tick();
    check("rst_valid",   64'(bus.valid),   64'd0);
    check("rst_id",      64'(bus.id),      64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    rst = 1'b0;
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("idle_ack_ignored", 64'(bus.valid), 64'd0);
    tick();

    // Priority: lines 2, 7, 0 together
    bus.req = 9'h085;
    tick();
    check("prio_pending", 64'(bus.pending), 64'h085);
    check("prio_no_valid_yet", 64'(bus.valid), 64'd0);
    bus.req = '0;
    tick();
    expect_grant("prio_first", 8);
    tick();
    expect_grant("prio_stable", 8);
    do_ack();
    check("prio_pending_after1", 64'(bus.pending), 64'h005);
    tick();
    expect_grant("prio_second", 3);
    do_ack();
    tick();
    expect_grant("prio_third", 1);
    do_ack();
    check("prio_pending_empty", 64'(bus.pending), 64'h000);
    tick();

    // Level vs edge: req[4] held for 20 cycles
    bus.req = 9'h010;
    tick();
    tick();
    expect_grant("level_grant", 5);
    do_ack();
    for (int i = 0; i < 17; i++) begin
      tick();
      check("level_no_regrant", 64'(bus.valid), 64'd0);
      check("level_no_overrun", 64'(bus.overrun), 64'd0);
    end
    bus.req = '0;
    tick();

    // Overrun and set-wins
    bus.req = 9'h002;
    tick();
    bus.req = '0;
    tick();
    expect_grant("ovr_grant", 2);
    bus.req = 9'h002;
    tick();
    check("ovr_pulse", 64'(bus.overrun), 64'd1);
    expect_grant("ovr_grant_held", 2);
    tick();
    check("ovr_one_cycle", 64'(bus.overrun), 64'd0);
    bus.req = '0;
    tick();
    bus.req = 9'h002;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = '0;
    check("setwins_pending", 64'(bus.pending), 64'h002);
    check("setwins_no_overrun", 64'(bus.overrun), 64'd0);
    check("setwins_valid_low", 64'(bus.valid), 64'd0);
    tick();
    expect_grant("setwins_regrant", 2);
    do_ack();
    tick();

    // Mask / stability
    bus.mask = 9'h0FF;
    bus.req  = 9'h108;
    tick();
    check("mask_pending", 64'(bus.pending), 64'h108);
    bus.req = '0;
    tick();
    expect_grant("mask_grant", 4);
    bus.mask = 9'h0F7;
    tick();
    tick();
    expect_grant("mask_held", 4);
    do_ack();
    check("mask_pending_left", 64'(bus.pending), 64'h100);
    tick();
    check("mask_blocked", 64'(bus.valid), 64'd0);
    bus.mask = 9'h1FF;
    tick();
    expect_grant("unmask_grant", 9);
    do_ack();
    tick();

    // Rotation: 8 and 6 pending, ack 9 while line 8 re-raises
    bus.req = 9'h140;
    tick();
    bus.req = '0;
    tick();
    expect_grant("rr_first", 9);
    bus.req = 9'h100;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("rr_pending", 64'(bus.pending), 64'h140);
    tick();
`ifdef PPE_ROUND_ROBIN_EN
    expect_grant("rr_rotated", 7);
`else
    expect_grant("fixed_not_rotated", 9);
`endif

    // Async reset mid-PRESENT
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid",   64'(bus.valid),   64'd0);
    check("async_rst_id",      64'(bus.id),      64'd0);
    check("async_rst_pending", 64'(bus.pending), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.req = '0;
    tick();
    bus.req = 9'h140;
    tick();
    bus.req = '0;
    tick();
    expect_grant("post_rst_fixed_start", 9);
    do_ack();
    tick();
    expect_grant("post_rst_second", 7);
    do_ack();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
